fft_spectrum_buffer: RTL

FFT_SPECTRUM_BUFFER -- requirements
Module: fft_spectrum_buffer

---
 rtl/fft_disp_pkg.sv | 11 +
 rtl/fft_spectrum_buffer_if.sv | 29 ++
 rtl/fft_spec_dpram.sv | 28 ++
 rtl/fft_spectrum_buffer.sv | 80 ++++++++
 4 files changed

// File: rtl/fft_disp_pkg.sv
// Shared sizing constants and write-FSM encoding for the FFT spectrum display buffer.
package fft_disp_pkg;

  localparam int FFT_POINTS = 512;
  localparam int FFT_DATA_W = 9;
  localparam int FFT_ADDR_W = 9;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

endpackage

// File: rtl/fft_spectrum_buffer_if.sv
// FFT-side write stream plus display-side read strobes of the spectrum buffer.
interface fft_spectrum_buffer_if
  import fft_disp_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int ADDR_W = FFT_ADDR_W
);

  logic [DATA_W-1:0] fft_data;
  logic              fft_valid;
  logic              fft_eop;
  logic              data_req;
  logic              fft_point_done;
  logic [ADDR_W-1:0] fft_point_cnt;
  logic [DATA_W-1:0] ram_data_out;
  logic              frame_swap;
  logic              frame_drop;

  modport master (
    output fft_data, fft_valid, fft_eop, data_req, fft_point_done,
    input  fft_point_cnt, ram_data_out, frame_swap, frame_drop
  );

  modport slave (
    input  fft_data, fft_valid, fft_eop, data_req, fft_point_done,
    output fft_point_cnt, ram_data_out, frame_swap, frame_drop
  );

endinterface

// File: rtl/fft_spec_dpram.sv
// Simple dual-port RAM, one write port and one registered read port, addressed as {bank, point}.
module fft_spec_dpram #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)     rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_spectrum_buffer.sv
// Ping-pong spectrum buffer: the FFT fills one bank while the display reads the other.
module fft_spectrum_buffer
  import fft_disp_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int POINTS = FFT_POINTS,
  parameter int ADDR_W = FFT_ADDR_W
) (
  input  logic clk,
  input  logic rst,
  fft_spectrum_buffer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_PT = ADDR_W'(POINTS - 1);

  logic [0:0]        wr_state;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_done;
  logic              wr_en;
  logic              rd_en;
  logic              swap;

  // NOTE: combinational decode uses blocking assignments with every output assigned, so no latch.
  always_comb begin
    rd_en = bus.data_req && !bus.fft_point_done;
    wr_en = !rst && (wr_state == ST_FILL) && bus.fft_valid && !wr_done;
    swap  = (wr_state == ST_FULL) && bus.fft_point_done;
  end

  // NOTE: all state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state          <= ST_FILL;
      wr_bank           <= 1'b0;
      wr_addr           <= '0;
      wr_done           <= 1'b0;
      bus.fft_point_cnt <= '0;
      bus.frame_swap    <= 1'b0;
      bus.frame_drop    <= 1'b0;
    end else begin
      bus.frame_swap <= swap;
      bus.frame_drop <= (wr_state == ST_FULL) && bus.fft_valid;

      if (bus.fft_point_done)
        bus.fft_point_cnt <= '0;
      else if (bus.data_req)
        bus.fft_point_cnt <= (bus.fft_point_cnt == LAST_PT) ? '0 : bus.fft_point_cnt + 1'b1;

      if (swap) begin
        wr_state <= ST_FILL;
        wr_bank  <= ~wr_bank;
        wr_addr  <= '0;
        wr_done  <= 1'b0;
      end else if ((wr_state == ST_FILL) && bus.fft_valid) begin
        if (bus.fft_eop) wr_state <= ST_FULL;
        // wr_done marks the last location as used so overlong frames stop writing.
        if (!wr_done) begin
          if (wr_addr == LAST_PT) wr_done <= 1'b1;
          else                    wr_addr <= wr_addr + 1'b1;
        end
      end
    end
  end

  fft_spec_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .wr_addr ({wr_bank, wr_addr}),
    .wr_data (bus.fft_data),
    .re      (rd_en),
    .rd_addr ({~wr_bank, bus.fft_point_cnt}),
    .rd_data (bus.ram_data_out)
  );

endmodule
